memory_responder: RTL

Responder end of the CPU memory bus: services load/store requests from the data-side memory controller and instruction fetches from the PC path against one shared single-port 32-bit word store. It arbitrates the two requesters, inserts configurable wait states and returns a one-cycle ready pulse per transaction. It replaces the pair of combinational RAM instances with one sequential, handshaked memory.

---
 rtl/memory_pkg.sv | 27 ++
 rtl/memory_responder_ram_array.sv | 29 ++
 rtl/memory_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared encodings for the memory responder: FSM states, bus direction, owner tags
// and the address range check used at grant and commit.
package memory_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    // True when a word address falls outside the populated part of the store.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr, input int depth);
        return 32'(addr) >= $unsigned(depth);
    endfunction

endpackage

// File: rtl/memory_responder_ram_array.sv
// Single-port word store: synchronous write and registered read, both issued
// by the responder on the edge that commits a transaction.
module ram_array
    import memory_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; only the access port is clocked.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Handshaked responder for the data and instruction sides of the CPU bus, sharing
// one single-port word store with round-robin arbitration and programmable wait states.
module memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_address,
    output logic [DATA_W-1:0] instruction,
    output logic              inst_ready,
    output logic              addr_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    logic [3:0]        wait_cnt;
    owner_t            last_grant;
    owner_t            lat_owner;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_rw;
    logic [DATA_W-1:0] lat_data;
    logic              lat_oob;
    logic [DATA_W-1:0] data_hold;
    logic [DATA_W-1:0] inst_hold;

    logic              grant_any;
    owner_t            grant_owner;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic              sel_oob;

    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rw;
    logic [DATA_W-1:0] c_data;
    logic              c_oob;

    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] read_word;

    // Arbiter: on contention the side that did not win last time gets the grant.
    always_comb begin
        grant_any   = en | fetch_req;
        grant_owner = OWN_FETCH;
        if (en && fetch_req) begin
            grant_owner = (last_grant == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (en) begin
            grant_owner = OWN_DATA;
        end
        sel_addr = (grant_owner == OWN_DATA) ? address : pc_address;
        sel_rw   = (grant_owner == OWN_DATA) ? rw : RW_READ;
        sel_oob  = addr_oob(sel_addr, DEPTH);
    end

    // With no wait states the commit happens on the grant edge, so the store
    // must see the live request instead of the latched copy.
    always_comb begin
        commit = 1'b0;
        c_addr = lat_addr;
        c_rw   = lat_rw;
        c_data = lat_data;
        if (state == IDLE && grant_any && WAIT_STATES == 0) begin
            commit = 1'b1;
            c_addr = sel_addr;
            c_rw   = sel_rw;
            c_data = datain;
        end else if (state == WAIT && wait_cnt == 4'd0) begin
            commit = 1'b1;
        end
        c_oob  = addr_oob(c_addr, DEPTH);
        ram_we = commit && (c_rw == RW_WRITE) && !c_oob;
        ram_re = commit && (c_rw == RW_READ) && !c_oob;
    end

    ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (c_addr[IDX_W-1:0]),
        .wdata (c_data),
        .rdata (ram_rdata)
    );

    assign read_word = lat_oob ? '0 : ram_rdata;

    // During RESPOND the freshly registered word is shown; afterwards the hold copy.
    assign dataout     = (state == RESPOND && lat_owner == OWN_DATA && lat_rw == RW_READ)
                         ? read_word : data_hold;
    assign instruction = (state == RESPOND && lat_owner == OWN_FETCH)
                         ? read_word : inst_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= OWN_FETCH;
            lat_owner  <= OWN_DATA;
            lat_addr   <= '0;
            lat_rw     <= RW_READ;
            lat_data   <= '0;
            lat_oob    <= 1'b0;
            data_hold  <= '0;
            inst_hold  <= '0;
            ready      <= 1'b0;
            inst_ready <= 1'b0;
            addr_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ready      <= 1'b0;
            inst_ready <= 1'b0;
            addr_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_owner;
                        lat_owner  <= grant_owner;
                        lat_addr   <= sel_addr;
                        lat_rw     <= sel_rw;
                        lat_data   <= datain;
                        lat_oob    <= sel_oob;
                        busy       <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state      <= RESPOND;
                            ready      <= (grant_owner == OWN_DATA);
                            inst_ready <= (grant_owner == OWN_FETCH);
                            addr_err   <= sel_oob;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= RESPOND;
                        ready      <= (lat_owner == OWN_DATA);
                        inst_ready <= (lat_owner == OWN_FETCH);
                        addr_err   <= lat_oob;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (lat_rw == RW_READ) begin
                        if (lat_owner == OWN_DATA) begin
                            data_hold <= read_word;
                        end else begin
                            inst_hold <= read_word;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
